// File: rtl/riscv_alu_pkg.sv
// riscv_alu_pkg: shared opcodes, width default and shifter mode type for the execute-stage ALU.
package riscv_alu_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SLL    = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_SLTU   = 4'b0110;
  localparam logic [3:0] ALU_SLT    = 4'b0111;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_SRA    = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_mode_e;
endpackage

// File: rtl/riscv_alu_if.sv
// riscv_alu_if: operand/result bundle between the ALU-control side and the ALU.
// overflow_flag exists only when ALU_OVERFLOW_EN is defined.
interface riscv_alu_if import riscv_alu_pkg::*; #(parameter int XLEN = XLEN_DEFAULT) ();
  logic            in_valid;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic [3:0]      alu_control_signal;
  logic            out_valid;
  logic [XLEN-1:0] alu_result;
  logic            zero_flag;
`ifdef ALU_OVERFLOW_EN
  logic            overflow_flag;
  modport master (output in_valid, in1, in2, alu_control_signal,
                  input out_valid, alu_result, zero_flag, overflow_flag);
  modport slave  (input in_valid, in1, in2, alu_control_signal,
                  output out_valid, alu_result, zero_flag, overflow_flag);
`else
  modport master (output in_valid, in1, in2, alu_control_signal,
                  input out_valid, alu_result, zero_flag);
  modport slave  (input in_valid, in1, in2, alu_control_signal,
                  output out_valid, alu_result, zero_flag);
`endif
endinterface

// File: rtl/riscv_alu_shifter.sv
// riscv_alu_shifter: combinational SLL/SRL/SRA on a 5-bit shift amount.
module riscv_alu_shifter import riscv_alu_pkg::*; #(parameter int XLEN = XLEN_DEFAULT) (
  input  logic [XLEN-1:0] i_data,
  input  logic [4:0]      i_shamt,
  input  shift_mode_e     i_mode,
  output logic [XLEN-1:0] o_result
);
  logic [XLEN-1:0] w_sll, w_srl, w_sra;
  assign w_sll = i_data << i_shamt;
  assign w_srl = i_data >> i_shamt;
  assign w_sra = $signed(i_data) >>> i_shamt;
  assign o_result = i_mode == SH_SRA ? w_sra : i_mode == SH_SRL ? w_srl : w_sll;
endmodule

// File: rtl/riscv_alu.sv
// riscv_alu: 32-bit RISC-V execute ALU, combinational op select with registered result/zero flag.
// Optional ALU_OVERFLOW_EN adds a registered signed-overflow flag for ADD/SUB.
module riscv_alu import riscv_alu_pkg::*; #(parameter int XLEN = XLEN_DEFAULT) (
  input logic       clk,
  input logic       rst_n,
  riscv_alu_if.slave bus
);
  logic [XLEN-1:0] w_sum, w_diff, w_shift, w_result;
  logic            w_slt, w_sltu;
  shift_mode_e     w_mode;
  logic            r_valid, r_zero;
  logic [XLEN-1:0] r_result;
  assign w_sum  = bus.in1 + bus.in2;
  assign w_diff = bus.in1 - bus.in2;
  assign w_slt  = $signed(bus.in1) < $signed(bus.in2);
  assign w_sltu = bus.in1 < bus.in2;
  assign w_mode = bus.alu_control_signal == ALU_SRA ? SH_SRA :
                  bus.alu_control_signal == ALU_SRL ? SH_SRL : SH_SLL;
  riscv_alu_shifter #(.XLEN(XLEN)) u_shifter (
    .i_data  (bus.in1),
    .i_shamt (bus.in2[4:0]),
    .i_mode  (w_mode),
    .o_result(w_shift)
  );
  always_comb begin
    w_result = '0;
    case (bus.alu_control_signal)
      ALU_AND:    w_result = bus.in1 & bus.in2;
      ALU_OR:     w_result = bus.in1 | bus.in2;
      ALU_ADD:    w_result = w_sum;
      ALU_XOR:    w_result = bus.in1 ^ bus.in2;
      ALU_SUB:    w_result = w_diff;
      ALU_SLT:    w_result = {{(XLEN-1){1'b0}}, w_slt};
      ALU_SLTU:   w_result = {{(XLEN-1){1'b0}}, w_sltu};
      ALU_SLL, ALU_SRL, ALU_SRA: w_result = w_shift;
      ALU_PASS_B: w_result = bus.in2;
      default:    w_result = '0;
    endcase
  end
`ifdef ALU_OVERFLOW_EN
  logic w_ovf, r_ovf;
  assign w_ovf = bus.alu_control_signal == ALU_ADD ?
                   (bus.in1[XLEN-1] == bus.in2[XLEN-1]) && (w_sum[XLEN-1] != bus.in1[XLEN-1]) :
                 bus.alu_control_signal == ALU_SUB ?
                   (bus.in1[XLEN-1] != bus.in2[XLEN-1]) && (w_diff[XLEN-1] != bus.in1[XLEN-1]) :
                 1'b0;
  always_ff @(posedge clk) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (bus.in_valid) r_ovf <= w_ovf;
  end
  assign bus.overflow_flag = r_ovf;
`endif
  // zero_flag is derived from the same next-state value so it never disagrees with alu_result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_result <= w_result;
        r_zero   <= w_result == '0;
      end
    end
  end
  assign bus.out_valid  = r_valid;
  assign bus.alu_result = r_result;
  assign bus.zero_flag  = r_zero;
endmodule

// File: tb/tb_riscv_alu.sv
// tb_riscv_alu: directed vectors for riscv_alu; overflow checks are active when ALU_OVERFLOW_EN is defined.
module tb_riscv_alu;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  riscv_alu_if #(.XLEN(32)) bus ();
  riscv_alu #(.XLEN(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input logic ov);
    logic ov_got;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in1 = a;
    bus.in2 = b;
    bus.alu_control_signal = c;
    @(posedge clk);
    #1;
    chk({tag, "/res"}, bus.alu_result, exp);
    chk({tag, "/zero"}, {31'b0, bus.zero_flag}, {31'b0, exp == 32'h0});
    chk({tag, "/valid"}, {31'b0, bus.out_valid}, 32'h1);
`ifdef ALU_OVERFLOW_EN
    ov_got = bus.overflow_flag;
    chk({tag, "/ovf"}, {31'b0, ov_got}, {31'b0, ov});
`else
    ov_got = ov;
`endif
  endtask
  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.alu_control_signal = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/res", bus.alu_result, 32'h0);
    chk("rst/zero", {31'b0, bus.zero_flag}, 32'h1);
    chk("rst/valid", {31'b0, bus.out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    op("and",   4'b0000, 32'd4, 32'd12, 32'd4, 1'b0);
    op("or",    4'b0001, 32'd4, 32'd12, 32'd12, 1'b0);
    op("add",   4'b0010, 32'd4, 32'd12, 32'd16, 1'b0);
    op("xor",   4'b0100, 32'd4, 32'd12, 32'd8, 1'b0);
    op("sub",   4'b1000, 32'd4, 32'd12, 32'hFFFF_FFF8, 1'b0);
    op("subz",  4'b1000, 32'd12, 32'd12, 32'h0, 1'b0);
    op("slt",   4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    op("sltu",  4'b0110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    op("ill",   4'b1111, 32'd4, 32'd12, 32'd0, 1'b0);
    op("ill_b", 4'b1011, 32'hDEAD_BEEF, 32'd7, 32'd0, 1'b0);
    op("sll",   4'b0011, 32'd1, 32'h21, 32'd2, 1'b0);
    op("sra",   4'b1001, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    op("sra_p", 4'b1001, 32'h7000_0000, 32'd4, 32'h0700_0000, 1'b0);
    op("srl",   4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
    op("passb", 4'b1010, 32'd9, 32'h1234_5000, 32'h1234_5000, 1'b0);
    op("wrap",  4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
    op("addov", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1);
    op("subov", 4'b1000, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1);
    op("addok", 4'b0010, 32'd4, 32'd12, 32'd16, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in1 = 32'h5555_0000;
    bus.alu_control_signal = 4'b0010;
    repeat (2) @(posedge clk);
    #1;
    chk("hold/res", bus.alu_result, 32'd16);
    chk("hold/zero", {31'b0, bus.zero_flag}, 32'h0);
    chk("hold/valid", {31'b0, bus.out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in1 = 32'd5;
    bus.in2 = 32'd5;
    bus.alu_control_signal = 4'b0010;
    @(posedge clk);
    #1;
    chk("rstv/res", bus.alu_result, 32'h0);
    chk("rstv/zero", {31'b0, bus.zero_flag}, 32'h1);
    chk("rstv/valid", {31'b0, bus.out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    op("post",  4'b0010, 32'd5, 32'd5, 32'd10, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
